// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and sizing for dispatch steering
package core_pkg;

    localparam int NUM_FUS     = 4;
    localparam int RS_ENTRIES  = 8;
    localparam int RS_CREDIT_W = $clog2(RS_ENTRIES + 1);
    localparam int FU_IDX_W    = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;

    localparam logic [RS_CREDIT_W-1:0] CREDIT_FULL = RS_CREDIT_W'(RS_ENTRIES);

    typedef struct packed {
        logic [5:0] rob_idx;
        logic [7:0] uop;
        logic [5:0] src1;
        logic [5:0] src2;
        logic [5:0] dst;
    } disp_packet_t;

endpackage

// File: rtl/max_credit_pick.sv
// rtl/max_credit_pick.sv - picks the eligible pipe with the most credits
module max_credit_pick
    import core_pkg::*;
(
    input  logic [NUM_FUS-1:0]                  eligible,
    input  logic [NUM_FUS-1:0][RS_CREDIT_W-1:0] credits,
    output logic [FU_IDX_W-1:0]                 pick_idx,
    output logic                                pick_valid
);

    logic [RS_CREDIT_W-1:0] best;

    // Strict greater-than keeps the lowest index on a tie.
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        best       = '0;
        for (int i = 0; i < NUM_FUS; i++) begin
            if (eligible[i] && (!pick_valid || credits[i] > best)) begin
                pick_valid = 1'b1;
                best       = credits[i];
                pick_idx   = FU_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_dispatch_steer.sv
// rtl/rs_dispatch_steer.sv - credit-based steering of dispatched uops to per-pipe schedulers
module rs_dispatch_steer
    import core_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  disp_packet_t                   in_pkt,
    input  logic [NUM_FUS-1:0]             in_fu_mask,
    output logic [NUM_FUS-1:0]             out_valid,
    output disp_packet_t                   out_pkt,
    input  logic [NUM_FUS-1:0]             fire,
    output logic [NUM_FUS*RS_CREDIT_W-1:0] credits_out
);

    logic [NUM_FUS-1:0][RS_CREDIT_W-1:0] credit;
    logic [NUM_FUS-1:0]                  eligible;
    logic [NUM_FUS-1:0]                  target;
    logic [FU_IDX_W-1:0]                 pick_idx;
    logic                                pick_valid;
    logic                                transfer;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_FUS; i++) begin
            eligible[i] = in_fu_mask[i] && (credit[i] != '0);
        end
    end

    max_credit_pick u_pick (
        .eligible   (eligible),
        .credits    (credit),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    assign in_ready    = !rst && !flush && pick_valid;
    assign transfer    = in_valid && in_ready;
    assign target      = transfer ? (NUM_FUS'(1) << pick_idx) : '0;
    assign credits_out = credit;

    // Credits only see the registered state, so a fire frees an entry for the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit    <= {NUM_FUS{CREDIT_FULL}};
            out_valid <= '0;
            out_pkt   <= '0;
        end else if (flush) begin
            credit    <= {NUM_FUS{CREDIT_FULL}};
            out_valid <= '0;
        end else begin
            out_valid <= target;
            if (transfer) begin
                out_pkt <= in_pkt;
            end
            for (int i = 0; i < NUM_FUS; i++) begin
                if (target[i] && !fire[i]) begin
                    credit[i] <= credit[i] - 1'b1;
                end else if (fire[i] && !target[i] && credit[i] != CREDIT_FULL) begin
                    credit[i] <= credit[i] + 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(out_valid)) else $error("out_valid not one-hot-or-zero");
            for (int i = 0; i < NUM_FUS; i++) begin
                assert (!(target[i] && credit[i] == '0)) else $error("credit underflow on pipe %0d", i);
                assert (!(!flush && fire[i] && credit[i] == CREDIT_FULL)) else $error("fire at full credit on pipe %0d", i);
            end
        end
    end
`endif

endmodule
